memstream_rd_seq: RTL and testbench
===================================

MEMSTREAM_RD_SEQ -- requirements
Module: memstream_rd_seq

Interface (parameters: name, default, meaning)
REQ-001 The block SHALL have parameter DWIDTH, default 18, as the data width of the RAM read port and the output stream.
REQ-002 The block SHALL have parameter AWIDTH, default 10, as the RAM address width.
REQ-003 The block SHALL have parameter START_ADDR, default 0, as the first address of the read window.
REQ-004 The block SHALL have parameter END_ADDR, default 2**AWIDTH-1, as the last address of the read window (inclusive); START_ADDR <= END_ADDR is required.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, as the output buffer depth; it SHALL be a power of 2 and >= 4.

Interface (ports: name, direction, width, meaning)
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-008 The block SHALL have port en, input, 1 bit; when high, new reads may be issued.
REQ-009 The block SHALL have the following RAM-side ports, which connect to the RAM read port:
- enb, output, 1 bit: read enable.
- enqb, output, 1 bit: output-register enable.
- addrb, output, AWIDTH bits: read address.
- rdqb, input, DWIDTH bits: read data.
REQ-010 The block SHALL have the following AXI-Stream master ports:
- m_axis_tdata, output, DWIDTH bits.
- m_axis_tvalid, output, 1 bit.
- m_axis_tready, input, 1 bit.
- m_axis_tlast, output, 1 bit: marks the END_ADDR word.

Function
REQ-011 RAM read latency SHALL be treated as 2 cycles:
- A read issued with enb=1 at cycle t SHALL drive enqb=1 at cycle t+1.
- rdqb SHALL be captured into the FIFO at cycle t+2.
- The RAM pipeline SHALL never stall; enqb equals enb delayed by one cycle.
REQ-012 A read SHALL issue (enb=1) in a cycle only if both of the following hold; otherwise enb=0:
- en=1.
- (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
REQ-013 The in-flight count SHALL have a range of 0..2. It SHALL increment on issue and decrement on capture; simultaneous issue and capture SHALL leave it unchanged.
REQ-014 Address sequencing:
- addrb SHALL present the current read address combinationally with enb.
- The address SHALL advance by 1 after each issue.
- The address SHALL wrap from END_ADDR to START_ADDR.
- The address SHALL not change when enb=0.
REQ-015 A last-flag SHALL travel alongside each read through the 2-stage pipeline and be stored in the FIFO with its data. It SHALL be set iff the issued address equals END_ADDR.
REQ-016 FIFO behaviour:
- Capacity is FIFO_DEPTH words of {last, data}.
- m_axis_tvalid SHALL equal "FIFO not empty".
- m_axis_tdata and m_axis_tlast SHALL be driven from the head entry.
- A pop occurs on tvalid && tready.
- Simultaneous push and pop SHALL keep occupancy constant and SHALL be legal when full or empty.
REQ-017 The FIFO SHALL never overflow. The credit rule in REQ-012 guarantees this; writing to a full FIFO is a design error and SHALL be flagged by an assertion.
REQ-018 Sustained throughput SHALL be 1 word per cycle when en=1 and tready=1 continuously.
REQ-019 First-word latency: with en=1, the first enb SHALL occur in the first cycle after rst deasserts, and m_axis_tvalid SHALL rise 3 cycles after that enb.
REQ-020 AXI-Stream stability: once tvalid=1 it SHALL stay high, and tdata/tlast SHALL stay stable, until accepted.
REQ-021 Deasserting en SHALL stop new issues only; in-flight reads SHALL still complete into the FIFO and drain normally.
REQ-022 When START_ADDR == END_ADDR, every word SHALL carry tlast=1 and the address SHALL stay constant.

Reset
REQ-023 While rst=1, the block SHALL hold the following values, taking effect at the next clock edge:
- enb=0, enqb=0.
- addrb=START_ADDR.
- m_axis_tvalid=0, m_axis_tlast=0.
- FIFO empty, in-flight count 0, pipeline last-flags cleared.
REQ-024 Asserting rst mid-stream SHALL discard all in-flight and buffered words. After release, the sequence SHALL restart at START_ADDR with no stale word emitted.

Verification
REQ-025 Streaming: START_ADDR=0, END_ADDR=3, mem[k]=0x100+k, en=1, tready=1 -> tdata sequence 0x100,0x101,0x102,0x103(tlast=1),0x100,..., tvalid continuously high from the 4th cycle after reset release.
REQ-026 Backpressure: tready=0 for 20 cycles after streaming starts -> exactly FIFO_DEPTH words buffered, enb stays 0 once credits are exhausted, tdata holds 0x100 stable; after tready=1 the sequence resumes without gap, loss or duplicate.
REQ-027 Random tready (50%) over 1000 accepted words -> the output matches the reference sequence exactly, tlast appears every 4th word, and no FIFO overflow assertion fires.
REQ-028 en dropped for 10 cycles mid-stream -> at most 2 further captures after the drop, and the stream resumes at the next address in order.
REQ-029 rst pulsed for 1 cycle while the FIFO holds 3 words -> tvalid=0 the next cycle, and the first word after restart is 0x100.
REQ-030 START_ADDR=END_ADDR=5, mem[5]=0x2AA -> every word is 0x2AA with tlast=1, and addrb stays constant at 5.

Source files
------------

// File: rtl/memstream_rd_seq.sv
// memstream_rd_seq: cyclic RAM window reader with 2-cycle read pipeline feeding an AXI-Stream FIFO.
// Reads are credit-limited so that in-flight reads plus buffered words never exceed FIFO_DEPTH.
module memstream_rd_seq #(
    parameter int DWIDTH     = 18,
    parameter int AWIDTH     = 10,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2**AWIDTH-1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              enb,
    output logic              enqb,
    output logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] rdqb,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AWIDTH-1:0] SA = AWIDTH'(START_ADDR);
    localparam logic [AWIDTH-1:0] EA = AWIDTH'(END_ADDR);
    localparam logic [PW+1:0] CREDITS = (PW+2)'(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    logic [AWIDTH-1:0] addr;
    logic [1:0] inflight;
    logic cap, l1, l2, push, pop;
    logic [PW-1:0] wp, rp;
    logic [PW:0] count;
    logic [DWIDTH:0] mem [FIFO_DEPTH];
    // Credit check counts reads still in the RAM pipeline as already occupying the FIFO.
    assign enb = en && !rst && (({1'b0, count} + {{PW{1'b0}}, inflight}) < CREDITS);
    assign addrb = addr;
    assign push = cap;
    assign pop = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = count != '0;
    assign m_axis_tdata = mem[rp][DWIDTH-1:0];
    assign m_axis_tlast = m_axis_tvalid && mem[rp][DWIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= SA;
            enqb     <= 1'b0;
            cap      <= 1'b0;
            l1       <= 1'b0;
            l2       <= 1'b0;
            inflight <= 2'd0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            if (enb) addr <= (addr == EA) ? SA : addr + 1'b1;
            enqb     <= enb;
            cap      <= enqb;
            l1       <= enb && (addr == EA);
            l2       <= l1;
            inflight <= inflight + {1'b0, enb} - {1'b0, cap};
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {l2, rdqb};
    end
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && count == FULL));
    end
endmodule

// File: tb/tb_memstream_rd_seq.sv
// tb_memstream_rd_seq: randomized directed bench with a sequence-level reference model for memstream_rd_seq.
module tb_memstream_rd_seq;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, tready = 1'b1;
    logic enb0, enqb0, tvalid0, tlast0, enb1, enqb1, tvalid1, tlast1;
    logic [9:0] addr0, addr1;
    logic [17:0] rdq0, rdq1, rr0, rr1, tdata0, tdata1;
    int checks = 0, errors = 0;
    int n = 0, acc = 0, issued = 0, caps = 0;
    logic s_enb, s_enq, s_valid, s_last, stall = 1'b0, prev_enq = 1'b0, pl;
    logic [9:0] s_addr;
    logic [17:0] s_data, pd;

    always #5 clk = ~clk;

    memstream_rd_seq #(.DWIDTH(18), .AWIDTH(10), .START_ADDR(0), .END_ADDR(3), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .enb(enb0), .enqb(enqb0), .addrb(addr0), .rdqb(rdq0),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready), .m_axis_tlast(tlast0));
    memstream_rd_seq #(.DWIDTH(18), .AWIDTH(10), .START_ADDR(5), .END_ADDR(5), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .enb(enb1), .enqb(enqb1), .addrb(addr1), .rdqb(rdq1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready), .m_axis_tlast(tlast1));

    function automatic logic [17:0] ram(input logic [9:0] a);
        return (a == 10'd5) ? 18'h2AA : 18'h100 + 18'(a);
    endfunction

    // Two-cycle RAM: array read register then output register.
    always_ff @(posedge clk) begin
        if (enb0) rr0 <= ram(addr0);
        if (enqb0) rdq0 <= rr0;
        if (enb1) rr1 <= ram(addr1);
        if (enqb1) rdq1 <= rr1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_enb = enb0; s_enq = enqb0; s_valid = tvalid0; s_last = tlast0; s_data = tdata0; s_addr = addr0;
        if (rst) begin
            n = 0; stall = 1'b0; prev_enq = 1'b0;
        end else begin
            if (enb0) issued++;
            if (prev_enq) caps++;
            if (stall) begin
                check("hold_valid", 32'(tvalid0), 32'd1);
                check("hold_word", 32'({tlast0, tdata0}), 32'({pl, pd}));
            end
            if (tvalid0 && tready) begin
                check("data", 32'(tdata0), 32'h100 + 32'(n % 4));
                check("last", 32'(tlast0), 32'(n % 4 == 3));
                n++; acc++;
            end
            stall = tvalid0 && !tready; pd = tdata0; pl = tlast0; prev_enq = enqb0;
            check("addr1", 32'(addr1), 32'd5);
            if (tvalid1 && tready) check("word1", 32'({tlast1, tdata1}), 32'({1'b1, 18'h2AA}));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, w;
        // reset values
        repeat (3) tick();
        check("rst_enb", 32'(s_enb), 32'd0);
        check("rst_enqb", 32'(s_enq), 32'd0);
        check("rst_addr", 32'(s_addr), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_last", 32'(s_last), 32'd0);
        // first-word latency and sustained streaming
        rst = 1'b0;
        tick();
        check("first_enb", 32'(s_enb), 32'd1);
        check("lat_valid0", 32'(s_valid), 32'd0);
        tick();
        check("lat_valid1", 32'(s_valid), 32'd0);
        tick();
        check("lat_valid2", 32'(s_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stream_valid", 32'(s_valid), 32'd1);
        end
        // backpressure from reset release
        rst = 1'b1; tready = 1'b0;
        repeat (2) tick();
        base = issued;
        rst = 1'b0;
        repeat (20) tick();
        check("bp_issued", 32'(issued - base), 32'd4);
        check("bp_enb", 32'(s_enb), 32'd0);
        check("bp_valid", 32'(s_valid), 32'd1);
        check("bp_head", 32'(s_data), 32'h100);
        tready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("bp_resume_valid", 32'(s_valid), 32'd1);
        end
        // random backpressure over 1000 accepted words
        base = acc; w = 0;
        while (acc - base < 1000 && w < 8000) begin
            tready = 1'($urandom % 2);
            tick();
            w++;
        end
        check("rand_count_reached", 32'(acc - base >= 1000), 32'd1);
        // en dropped mid-stream
        tready = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        base = caps;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("drop_enb", 32'(s_enb), 32'd0);
        end
        check("drop_caps", 32'(caps - base <= 2), 32'd1);
        check("drop_drained", 32'(s_valid), 32'd0);
        en = 1'b1;
        repeat (20) tick();
        // reset pulse while three words are buffered
        rst = 1'b1; tready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("pre_pulse_valid", 32'(s_valid), 32'd1);
        rst = 1'b0;
        tick();
        check("post_pulse_valid", 32'(s_valid), 32'd0);
        tready = 1'b1;
        w = 0;
        while (!s_valid && w < 10) begin
            tick();
            w++;
        end
        check("restart_valid", 32'(s_valid), 32'd1);
        check("restart_word", 32'(s_data), 32'h100);
        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
